// File: rtl/xadc_pkg.sv
// xadc_pkg: shared FSM encoding, channel tags and DRP address defaults for the XADC sequencer
package xadc_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;
    localparam logic CH_EMG = 1'b0;
    localparam logic CH_ECG = 1'b1;
    localparam logic [6:0] CH0_ADDR_DEF = 7'h13;
    localparam logic [6:0] CH1_ADDR_DEF = 7'h1B;
    localparam int ADC_RES = 12;
endpackage

// File: rtl/xadc_tick_gen.sv
// xadc_tick_gen: free-running 0..INTERVAL_CYCLES-1 counter, tick_o high on the wrap cycle
module xadc_tick_gen #(
    parameter int unsigned INTERVAL_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);
    localparam int W = $clog2(INTERVAL_CYCLES);
    logic [W-1:0] cnt_q;
    assign tick_o = (cnt_q == W'(INTERVAL_CYCLES - 1));
    always_ff @(posedge clk_i) begin
        cnt_q <= (rst_i || tick_o) ? '0 : cnt_q + 1'b1;
    end
endmodule

// File: rtl/xadc_drp_sequencer.sv
// xadc_drp_sequencer: handshaked DRP reads of CH0 then CH1 per tick; XADC_OVERRUN_CNT_EN adds dropped-tick counter
module xadc_drp_sequencer
    import xadc_pkg::*;
#(
    parameter logic [6:0]  CH0_ADDR        = CH0_ADDR_DEF,
    parameter logic [6:0]  CH1_ADDR        = CH1_ADDR_DEF,
    parameter int unsigned INTERVAL_CYCLES = 100000,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic               CLK100MHZ,
    input  logic               reset,
    output logic [6:0]         drp_daddr,
    output logic               drp_den,
    output logic               drp_dwe,
    output logic [15:0]        drp_di,
    input  logic [15:0]        drp_do,
    input  logic               drp_drdy,
    output logic [ADC_RES-1:0] sample_data,
    output logic               sample_ch,
    output logic               sample_err,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic [7:0]         overrun_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    state_t             state_q;
    logic               ch_q, pend_q, den_q, err_q, valid_q, tick;
    logic [TW-1:0]      tmo_q;
    logic [6:0]         addr_q;
    logic [ADC_RES-1:0] data_q;
    logic               unused_lsbs;

    xadc_tick_gen #(.INTERVAL_CYCLES(INTERVAL_CYCLES)) u_tick (
        .clk_i  (CLK100MHZ),
        .rst_i  (reset),
        .tick_o (tick)
    );

    assign drp_daddr    = addr_q;
    assign drp_den      = den_q;
    assign drp_dwe      = 1'b0;
    assign drp_di       = 16'h0000;
    assign sample_data  = data_q;
    assign sample_ch    = ch_q;
    assign sample_err   = err_q;
    assign sample_valid = valid_q;
    assign unused_lsbs  = ^drp_do[3:0];

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q <= IDLE;
            ch_q    <= CH_EMG;
            pend_q  <= 1'b0;
            tmo_q   <= '0;
            den_q   <= 1'b0;
            addr_q  <= CH0_ADDR;
            data_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            den_q  <= 1'b0;
            // a start in IDLE consumes the queued tick; elsewhere a tick is queued once
            pend_q <= (state_q == IDLE) ? 1'b0 : (pend_q | tick);
            case (state_q)
                IDLE: if (tick || pend_q) begin
                    state_q <= REQ;
                    ch_q    <= CH_EMG;
                    den_q   <= 1'b1;
                    addr_q  <= CH0_ADDR;
                end
                REQ: begin
                    state_q <= WAIT;
                    tmo_q   <= '0;
                end
                WAIT: if (drp_drdy || tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_q <= OUT;
                    valid_q <= 1'b1;
                    data_q  <= drp_drdy ? drp_do[15 -: ADC_RES] : '0;
                    err_q   <= !drp_drdy;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
                OUT: if (sample_ready) begin
                    valid_q <= 1'b0;
                    if (ch_q == CH_EMG) begin
                        state_q <= REQ;
                        ch_q    <= CH_ECG;
                        den_q   <= 1'b1;
                        addr_q  <= CH1_ADDR;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef XADC_OVERRUN_CNT_EN
    logic [7:0] ovr_q;
    always_ff @(posedge CLK100MHZ) begin
        if (reset)
            ovr_q <= 8'h00;
        else if (tick && pend_q && ovr_q != 8'hFF)
            ovr_q <= ovr_q + 8'h01;
    end
    assign overrun_cnt = ovr_q;
`else
    assign overrun_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// tb_xadc_drp_sequencer: directed self-checking bench for the XADC DRP sequencer
module tb_xadc_drp_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  drp_daddr;
    logic        drp_den, drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;
    logic [11:0] sample_data;
    logic        sample_ch, sample_err, sample_valid, sample_ready;
    logic [7:0]  overrun_cnt;
    int          n_cmp = 0;
    int          n_err = 0;

`ifdef XADC_OVERRUN_CNT_EN
    localparam logic [7:0] OVR_EXP = 8'd2;
`else
    localparam logic [7:0] OVR_EXP = 8'd0;
`endif

    xadc_drp_sequencer #(
        .CH0_ADDR(7'h13), .CH1_ADDR(7'h1B), .INTERVAL_CYCLES(300), .TIMEOUT_CYCLES(64)
    ) dut (
        .CLK100MHZ    (clk),
        .reset        (reset),
        .drp_daddr    (drp_daddr),
        .drp_den      (drp_den),
        .drp_dwe      (drp_dwe),
        .drp_di       (drp_di),
        .drp_do       (drp_do),
        .drp_drdy     (drp_drdy),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .sample_err   (sample_err),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_addr"}, drp_daddr, 7'h13);
        chk({tag, "_den"}, drp_den, 0);
        chk({tag, "_data"}, sample_data, 0);
        chk({tag, "_ch"}, sample_ch, 0);
        chk({tag, "_err"}, sample_err, 0);
        chk({tag, "_valid"}, sample_valid, 0);
        chk({tag, "_ovr"}, overrun_cnt, 0);
    endtask

    task automatic chk_beat(input string tag, input logic [11:0] d, input logic c, input logic e);
        chk({tag, "_valid"}, sample_valid, 1);
        chk({tag, "_data"}, sample_data, d);
        chk({tag, "_ch"}, sample_ch, c);
        chk({tag, "_err"}, sample_err, e);
    endtask

    // caller is at a negedge; returns at the negedge where den is seen
    task automatic wait_den(input string tag, input logic [6:0] addr, input int lim);
        int i = 0;
        while (drp_den !== 1'b1 && i < lim) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_den"}, drp_den, 1);
        chk({tag, "_addr"}, drp_daddr, addr);
    endtask

    // from the den negedge: drdy seen by the DUT dly cycles after den; returns where the beat should show
    task automatic respond(input int dly, input logic [15:0] d);
        @(negedge clk);
        chk("den_single", drp_den, 0);
        repeat (dly - 1) @(negedge clk);
        drp_do   = d;
        drp_drdy = 1'b1;
        @(negedge clk);
        drp_drdy = 1'b0;
        drp_do   = 16'hFFFF;
    endtask

    initial begin
        reset = 1'b1; sample_ready = 1'b0; drp_drdy = 1'b0; drp_do = 16'h0000;
        repeat (3) @(negedge clk);
        chk_rst("rst");
        chk("dwe", drp_dwe, 0);
        chk("di", drp_di, 0);
        reset = 1'b0;

        // normal pair, ready held high
        sample_ready = 1'b1;
        wait_den("n0", 7'h13, 400);
        respond(3, 16'hABC0);
        chk_beat("n0", 12'hABC, 0, 0);
        @(negedge clk);
        chk("n0_drop", sample_valid, 0);
        wait_den("n1", 7'h1B, 1);
        respond(3, 16'h1230);
        chk_beat("n1", 12'h123, 1, 0);
        @(negedge clk);
        chk("n1_drop", sample_valid, 0);

        // backpressure on CH0
        sample_ready = 1'b0;
        wait_den("b0", 7'h13, 400);
        respond(3, 16'h5550);
        chk_beat("b0", 12'h555, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_beat("b0_hold", 12'h555, 0, 0);
            chk("b0_noden", drp_den, 0);
        end
        sample_ready = 1'b1;
        @(negedge clk);
        chk("b0_drop", sample_valid, 0);
        wait_den("b1", 7'h1B, 1);
        respond(2, 16'h7770);
        chk_beat("b1", 12'h777, 1, 0);

        // timeout on CH0: 64 WAIT cycles, beat one cycle later
        @(negedge clk);
        wait_den("t0", 7'h13, 400);
        repeat (64) @(negedge clk);
        chk("t0_early", sample_valid, 0);
        @(negedge clk);
        chk_beat("t0", 12'h000, 0, 1);
        @(negedge clk);
        wait_den("t1", 7'h1B, 1);
        respond(3, 16'h4560);
        chk_beat("t1", 12'h456, 1, 0);

        // drdy on the last WAIT cycle wins over the timeout
        @(negedge clk);
        wait_den("s0", 7'h13, 400);
        respond(64, 16'h9870);
        chk_beat("s0", 12'h987, 0, 0);
        @(negedge clk);
        wait_den("s1", 7'h1B, 1);
        respond(1, 16'h0010);
        chk_beat("s1", 12'h001, 1, 0);

        // reset in WAIT, late drdy ignored
        @(negedge clk);
        wait_den("r0", 7'h13, 400);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_rst("r_mid");
        reset = 1'b0;
        sample_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        drp_do = 16'hABCD; drp_drdy = 1'b1;
        @(negedge clk);
        drp_drdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("r_novalid", sample_valid, 0);
            chk("r_noden", drp_den, 0);
        end
        chk("r_data", sample_data, 0);

        // overrun: den at R from tick R-1; ticks at R+299/599/899 queue one, drop two
        wait_den("o0", 7'h13, 400);
        respond(3, 16'h1110);
        chk_beat("o0", 12'h111, 0, 0);
        repeat (996) @(negedge clk);
        chk_beat("o0_hold", 12'h111, 0, 0);
        chk("o0_ovr", overrun_cnt, OVR_EXP);
        sample_ready = 1'b1;
        @(negedge clk);
        wait_den("o1", 7'h1B, 1);
        respond(3, 16'hCCC0);
        chk_beat("o1", 12'hCCC, 1, 0);
        @(negedge clk);
        chk("o_idle_den", drp_den, 0);
        chk("o_idle_valid", sample_valid, 0);
        @(negedge clk);
        wait_den("q0", 7'h13, 1);
        respond(3, 16'h2220);
        chk_beat("q0", 12'h222, 0, 0);
        @(negedge clk);
        wait_den("q1", 7'h1B, 1);
        respond(3, 16'h3330);
        chk_beat("q1", 12'h333, 1, 0);
        @(negedge clk);
        chk("q_ovr", overrun_cnt, OVR_EXP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
